debounce_bank: RTL

//  Multi-channel debouncer for board buttons/switches. Synchronises NCH raw inputs and filters bounce.

---
 rtl/debounce_pkg.sv | 31 +++
 rtl/debounce_chan.sv | 92 +++++++++
 rtl/debounce_bank.sv | 105 ++++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// debounce_pkg: shared event type and round-robin pick helper for debounce_bank
package debounce_pkg;

    localparam int MAX_NCH = 32;

    typedef struct packed {
        logic press;
        logic repeat_;
    } evt_t;

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } pick_t;

    // first set bit of pend searching ptr+1, ptr+2, ... modulo n
    function automatic pick_t rr_pick(input logic [MAX_NCH-1:0] pend, input logic [4:0] ptr, input int n);
        pick_t r;
        int    c;
        r = '0;
        for (int k = 1; k <= MAX_NCH; k++) begin
            c = (int'(ptr) + k) % n;
            if (k <= n && !r.found && pend[c[4:0]]) begin
                r.found = 1'b1;
                r.idx   = c[4:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// debounce_chan: one channel of synchroniser, stability filter and edge pulses; DEBOUNCE_REPEAT_EN adds the auto-repeat hold counter
module debounce_chan #(
    parameter int STABLE_CYCLES = 255,
    parameter int SYNC_STAGES   = 2,
    parameter int REPEAT_DELAY  = 5000,
    parameter int REPEAT_PERIOD = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic in_raw,
    output logic out,
    output logic rise,
    output logic fall,
    output logic rpt
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   out_q, out_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s, accept;

    // count consecutive synchronised samples that disagree with the accepted level; accept on the last one
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], in_raw};
        s      = sync_q[SYNC_STAGES-1];
        accept = (s != out_q) && (cnt_q == CW'(STABLE_CYCLES - 1));
        cnt_d  = (s == out_q || accept) ? '0 : cnt_q + 1'b1;
        out_d  = accept ? s : out_q;
        rise_d = accept && s;
        fall_d = accept && !s;
    end

    // synchroniser, filter counter, level and pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            out_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign out  = out_q;
    assign rise = rise_q;
    assign fall = fall_q;

`ifdef DEBOUNCE_REPEAT_EN
    localparam int HW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);

    logic [HW-1:0] hold_q, hold_d;
    logic          rep_q, rep_d;
    logic          rpt_q, rpt_d;
    logic          hit;

    // hold counter runs while the level is high: first target is the delay, later targets the period
    always_comb begin
        hit    = out_q && (hold_q + 1'b1 == (rep_q ? HW'(REPEAT_PERIOD) : HW'(REPEAT_DELAY)));
        hold_d = (!out_d || rise_d || hit) ? '0 : hold_q + 1'b1;
        rep_d  = out_d && !rise_d && (rep_q || hit);
        rpt_d  = out_d && hit;
    end

    // hold counter and repeat pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
            rep_q  <= 1'b0;
            rpt_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            rep_q  <= rep_d;
            rpt_q  <= rpt_d;
        end
    end

    assign rpt = rpt_q;
`else
    assign rpt = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: NCH-channel debouncer with edge pulses and a round-robin press/release event stream; DEBOUNCE_REPEAT_EN enables auto-repeat events
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int NCH           = 4,
    parameter int STABLE_CYCLES = 255,
    parameter int SYNC_STAGES   = 2,
    parameter int REPEAT_DELAY  = 5000,
    parameter int REPEAT_PERIOD = 1000
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NCH-1:0]                         in,
    output logic [NCH-1:0]                         out,
    output logic [NCH-1:0]                         rise,
    output logic [NCH-1:0]                         fall,
    output logic                                   evt_valid,
    input  logic                                   evt_ready,
    output logic [(NCH > 1 ? $clog2(NCH) : 1)-1:0] evt_ch,
    output logic                                   evt_press,
    output logic                                   evt_repeat,
    output logic [NCH-1:0]                         ovf,
    input  logic [NCH-1:0]                         ovf_clr
);

    localparam int CHW = NCH > 1 ? $clog2(NCH) : 1;

    logic [NCH-1:0] rpt, ev, pend, grant;
    logic [NCH-1:0] slot_v_q, slot_v_d;
    logic [NCH-1:0] ovf_q, ovf_d;
    evt_t [NCH-1:0] slot_q, slot_d, ev_data, cand;
    logic [CHW-1:0] rr_q, rr_d;
    logic [CHW-1:0] evt_ch_q, evt_ch_d;
    logic [CHW-1:0] pick_idx;
    evt_t           evt_q, evt_d;
    logic           evt_valid_q, evt_valid_d;
    logic           adv;
    pick_t          pk;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        debounce_chan #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .SYNC_STAGES  (SYNC_STAGES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .in_raw(in[g]),
            .out   (out[g]),
            .rise  (rise[g]),
            .fall  (fall[g]),
            .rpt   (rpt[g])
        );
    end

    // an edge arriving at an empty slot bypasses straight to the arbiter; a full slot delivers its old event first
    always_comb begin
        ev          = rise | fall | rpt;
        pend        = slot_v_q | ev;
        adv         = !evt_valid_q || evt_ready;
        pk          = rr_pick(MAX_NCH'(pend), 5'(rr_q), NCH);
        pick_idx    = CHW'(pk.idx);
        grant       = (adv && pk.found) ? NCH'(1) << pick_idx : '0;
        for (int c = 0; c < NCH; c++) begin
            ev_data[c]  = {rise[c] | rpt[c], rpt[c]};
            cand[c]     = slot_v_q[c] ? slot_q[c] : ev_data[c];
            slot_v_d[c] = grant[c] ? slot_v_q[c] && ev[c] : slot_v_q[c] || ev[c];
            slot_d[c]   = ev[c] ? ev_data[c] : slot_q[c];
            ovf_d[c]    = (ovf_q[c] || (ev[c] && slot_v_q[c] && !grant[c])) && !ovf_clr[c];
        end
        evt_valid_d = adv ? pk.found : evt_valid_q;
        evt_d       = (adv && pk.found) ? cand[pick_idx] : evt_q;
        evt_ch_d    = (adv && pk.found) ? pick_idx : evt_ch_q;
        rr_d        = (adv && pk.found) ? pick_idx : rr_q;
    end

    // slots, sticky overflow flags, round-robin pointer and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_v_q    <= '0;
            slot_q      <= '0;
            ovf_q       <= '0;
            rr_q        <= CHW'(NCH - 1);
            evt_valid_q <= 1'b0;
            evt_q       <= '0;
            evt_ch_q    <= '0;
        end else begin
            slot_v_q    <= slot_v_d;
            slot_q      <= slot_d;
            ovf_q       <= ovf_d;
            rr_q        <= rr_d;
            evt_valid_q <= evt_valid_d;
            evt_q       <= evt_d;
            evt_ch_q    <= evt_ch_d;
        end
    end

    assign evt_valid  = evt_valid_q;
    assign evt_ch     = evt_ch_q;
    assign evt_press  = evt_q.press;
    assign evt_repeat = evt_q.repeat_;
    assign ovf        = ovf_q;

endmodule
